axisadd_stream_core: RTL and testbench

- Datapath stage directly downstream of the axisadd AXI4-Lite register slave. It consumes that slave's control registers and returns status to it.
- Joins two AXI-Stream inputs, A and B, each fed by one of the design's two FIFOs.
- Emits one output beat per joined pair: A + B + configured offset, with wrap or saturate mode.
- Keeps beat, packet and overflow counters plus a sticky tlast-mismatch flag. The register slave reads these back.

---
 rtl/axisadd_pkg.sv | 20 ++
 rtl/axisadd_skid_buf.sv | 56 +++++
 rtl/axisadd_stream_core.sv | 85 ++++++++
 tb/tb_axisadd_stream_core.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axisadd_pkg.sv
// Shared definitions for the axisadd stream datapath: widths, register map
// and the beat record carried through the output buffer.
package axisadd_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 32;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_SATURATE_BIT = 1;
  localparam int CTRL_CLEAR_BIT    = 2;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_OFFSET   = 4'h4;
  localparam logic [3:0] REG_BEAT_CNT = 4'h8;
  localparam logic [3:0] REG_PKT_CNT  = 4'hC;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } beat_t;
endpackage

// File: rtl/axisadd_skid_buf.sv
// Two-entry registered AXIS buffer. room is a register, so the upstream ready
// never combinationally depends on out_ready.
module axisadd_skid_buf
  import axisadd_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  T     in_beat,
  output logic room,
  output logic out_valid,
  output T     out_beat,
  input  logic out_ready
);
  logic [1:0] cnt, cnt_nxt;
  logic       push, pop;
  T           ent1;

  assign push = in_valid & room;
  assign pop  = out_valid & out_ready;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: ;
    endcase
  end

  // out_beat is the head entry, ent1 the overflow slot behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      room      <= 1'b0;
      out_valid <= 1'b0;
      out_beat  <= '0;
      ent1      <= '0;
    end else begin
      cnt       <= cnt_nxt;
      room      <= (cnt_nxt != 2'd2);
      out_valid <= (cnt_nxt != 2'd0);
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) out_beat <= in_beat;
          else             ent1     <= in_beat;
        end
        2'b01:   out_beat <= ent1;
        2'b11:   out_beat <= in_beat; // only reachable with one entry held
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/axisadd_stream_core.sv
// Joins streams A and B, emits A + B + offset (wrap or saturate) through a
// two-entry output buffer, and keeps the status counters for the reg slave.
module axisadd_stream_core
  import axisadd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] s_a_tdata,
  input  logic                  s_a_tvalid,
  input  logic                  s_a_tlast,
  output logic                  s_a_tready,
  input  logic [DATA_WIDTH-1:0] s_b_tdata,
  input  logic                  s_b_tvalid,
  input  logic                  s_b_tlast,
  output logic                  s_b_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  input  logic                  cfg_enable,
  input  logic                  cfg_saturate,
  input  logic                  cfg_clear,
  input  logic [DATA_WIDTH-1:0] cfg_offset,
  output logic [CNT_WIDTH-1:0]  sts_beat_cnt,
  output logic [CNT_WIDTH-1:0]  sts_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  sts_ovf_cnt,
  output logic                  sts_tlast_err
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_w_t;

  logic                  room, join_fire, ovf, out_fire;
  logic [DATA_WIDTH+1:0] sum;
  beat_w_t               in_beat, out_beat;

  // Both inputs handshake together or not at all.
  assign join_fire  = cfg_enable & s_a_tvalid & s_b_tvalid & room;
  assign s_a_tready = join_fire;
  assign s_b_tready = join_fire;

  assign sum          = {2'b00, s_a_tdata} + {2'b00, s_b_tdata} + {2'b00, cfg_offset};
  assign ovf          = |sum[DATA_WIDTH+1:DATA_WIDTH];
  assign in_beat.data = (cfg_saturate & ovf) ? '1 : sum[DATA_WIDTH-1:0];
  assign in_beat.last = s_a_tlast | s_b_tlast;

  axisadd_skid_buf #(.T(beat_w_t)) u_buf (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .in_valid  (join_fire),
    .in_beat   (in_beat),
    .room      (room),
    .out_valid (m_tvalid),
    .out_beat  (out_beat),
    .out_ready (m_tready)
  );

  assign m_tdata  = out_beat.data;
  assign m_tlast  = out_beat.last;
  assign out_fire = m_tvalid & m_tready;

  // Clear has priority over any same-cycle increment or set.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sts_beat_cnt  <= '0;
      sts_pkt_cnt   <= '0;
      sts_ovf_cnt   <= '0;
      sts_tlast_err <= 1'b0;
    end else if (cfg_clear) begin
      sts_beat_cnt  <= '0;
      sts_pkt_cnt   <= '0;
      sts_ovf_cnt   <= '0;
      sts_tlast_err <= 1'b0;
    end else begin
      if (out_fire)             sts_beat_cnt <= sts_beat_cnt + 1'b1;
      if (out_fire && m_tlast)  sts_pkt_cnt  <= sts_pkt_cnt + 1'b1;
      if (join_fire && ovf)     sts_ovf_cnt  <= sts_ovf_cnt + 1'b1;
      if (join_fire && (s_a_tlast != s_b_tlast)) sts_tlast_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axisadd_stream_core.sv
// Directed bench for axisadd_stream_core: inputs driven 2 time units after
// each rising edge, output handshakes logged at the falling edge.
module tb_axisadd_stream_core;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [DW-1:0] s_a_tdata, s_b_tdata, m_tdata, cfg_offset;
  logic          s_a_tvalid, s_a_tlast, s_a_tready;
  logic          s_b_tvalid, s_b_tlast, s_b_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic          cfg_enable, cfg_saturate, cfg_clear;
  logic [CW-1:0] sts_beat_cnt, sts_pkt_cnt, sts_ovf_cnt;
  logic          sts_tlast_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  int            q_cyc[$];

  axisadd_stream_core #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tlast(s_a_tlast), .s_a_tready(s_a_tready),
    .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tlast(s_b_tlast), .s_b_tready(s_b_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .cfg_enable(cfg_enable), .cfg_saturate(cfg_saturate), .cfg_clear(cfg_clear),
    .cfg_offset(cfg_offset),
    .sts_beat_cnt(sts_beat_cnt), .sts_pkt_cnt(sts_pkt_cnt), .sts_ovf_cnt(sts_ovf_cnt),
    .sts_tlast_err(sts_tlast_err)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc++;

  // Handshakes seen mid-cycle complete on the following rising edge.
  always @(negedge ACLK)
    if (ARESETN && m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_last.push_back(m_tlast);
      q_cyc.push_back(cyc);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_all();
    idle(3);
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    q_data.delete(); q_last.delete(); q_cyc.delete();
  endtask

  // Presents one A/B pair until it is joined (bounded), then drops valid.
  task automatic run_join(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic la, input logic lb);
    bit fire;
    int n;
    s_a_tdata = a; s_b_tdata = b; s_a_tlast = la; s_b_tlast = lb;
    s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
    n = 0;
    do begin
      #1;
      fire = s_a_tready;
      step();
      n++;
    end while (!fire && n < 20);
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    checks++;
    if (!fire) begin
      errors++;
      $display("FAIL join_timeout: a=%h b=%h never joined within %0d cycles", a, b, n);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b1;
    s_a_tdata = '0; s_b_tdata = '0; s_a_tlast = 0; s_b_tlast = 0;
    s_a_tvalid = 1'b1; s_b_tvalid = 1'b1; m_tready = 1'b1;
    cfg_enable = 1'b1; cfg_saturate = 1'b0; cfg_clear = 1'b0; cfg_offset = '0;
    #1 ARESETN = 1'b0;
    #2;
    checks++;
    if ({s_a_tready, s_b_tready} !== 2'b00) begin
      errors++; $display("FAIL reset_tready: got %b want 00", {s_a_tready, s_b_tready});
    end
    checks++;
    if ({m_tvalid, m_tlast, m_tdata} !== '0) begin
      errors++; $display("FAIL reset_out: valid=%b last=%b data=%h want 0", m_tvalid, m_tlast, m_tdata);
    end
    checks++;
    if ({sts_beat_cnt, sts_pkt_cnt, sts_ovf_cnt, sts_tlast_err} !== '0) begin
      errors++; $display("FAIL reset_sts: beat=%0d pkt=%0d ovf=%0d err=%b want 0",
                         sts_beat_cnt, sts_pkt_cnt, sts_ovf_cnt, sts_tlast_err);
    end
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    #9 ARESETN = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++)
      run_join(DW'(i + 1), DW'((i + 1) << 4), i == 3, i == 3);
    idle(3);
    checks++;
    if (q_data.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d beats want 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== exp_d[i] || q_last[i] !== (i == 3)) begin
          errors++; $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, q_data[i], q_last[i], exp_d[i], i == 3);
        end
      end
      checks++;
      if (q_cyc[3] - q_cyc[0] != 3) begin
        errors++; $display("FAIL basic_throughput: span %0d cycles want 3", q_cyc[3] - q_cyc[0]);
      end
    end
    checks++;
    if (sts_beat_cnt !== 4 || sts_pkt_cnt !== 1 || sts_ovf_cnt !== 0 || sts_tlast_err !== 1'b0) begin
      errors++; $display("FAIL basic_sts: beat=%0d pkt=%0d ovf=%0d err=%b want 4/1/0/0",
                         sts_beat_cnt, sts_pkt_cnt, sts_ovf_cnt, sts_tlast_err);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_d [4] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    clear_all();
    cfg_offset = 32'h1; cfg_saturate = 1'b0;
    run_join(32'hFFFFFFFF, 32'h2, 1, 1);
    cfg_saturate = 1'b1;
    run_join(32'hFFFFFFFF, 32'h2, 1, 1);
    cfg_offset = 32'h0;
    run_join(32'hFFFFFFFE, 32'h1, 1, 1);   // exactly all-ones, no overflow
    cfg_saturate = 1'b0;
    run_join(32'hFFFFFFFF, 32'h1, 1, 1);   // exactly 2^32, wraps to 0
    idle(3);
    checks++;
    if (q_data.size() != 4) begin
      errors++; $display("FAIL ovf_count: got %0d beats want 4", q_data.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== exp_d[i]) begin
          errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, q_data[i], exp_d[i]);
        end
      end
    checks++;
    if (sts_ovf_cnt !== 3) begin
      errors++; $display("FAIL ovf_cnt: got %0d want 3", sts_ovf_cnt);
    end
  endtask

  task automatic test_backpressure();
    int  idx;
    bit  fire;
    clear_all();
    m_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s_a_tdata = DW'(idx + 1); s_b_tdata = DW'((idx + 1) << 4);
      s_a_tlast = (idx == 4); s_b_tlast = (idx == 4);
      s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
      #1 fire = s_a_tready;
      if (c >= 2) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h11) begin
          errors++; $display("FAIL bp_stall_hold c%0d: valid=%b data=%h want 1/00000011", c, m_tvalid, m_tdata);
        end
      end
      step();
      if (fire) idx++;
    end
    checks++;
    if (idx != 2 || s_a_tready !== 1'b0 || s_b_tready !== 1'b0) begin
      errors++; $display("FAIL bp_joins: joins=%0d tready=%b%b want 2 and 00", idx, s_a_tready, s_b_tready);
    end
    m_tready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      s_a_tdata = DW'(idx + 1); s_b_tdata = DW'((idx + 1) << 4);
      s_a_tlast = (idx == 4); s_b_tlast = (idx == 4);
      #1 fire = s_a_tready;
      step();
      if (fire) idx++;
    end
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0; s_a_tlast = 0; s_b_tlast = 0;
    idle(4);
    checks++;
    if (q_data.size() != 5) begin
      errors++; $display("FAIL bp_count: got %0d beats want 5", q_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q_data[i] !== DW'(32'h11 * (i + 1)) || q_last[i] !== (i == 4)) begin
          errors++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, q_data[i], q_last[i], 32'h11 * (i + 1), i == 4);
        end
      end
      checks++;
      if (q_cyc[4] - q_cyc[0] != 4) begin
        errors++; $display("FAIL bp_throughput: span %0d cycles want 4", q_cyc[4] - q_cyc[0]);
      end
    end
    checks++;
    if (sts_beat_cnt !== 5 || sts_pkt_cnt !== 1) begin
      errors++; $display("FAIL bp_sts: beat=%0d pkt=%0d want 5/1", sts_beat_cnt, sts_pkt_cnt);
    end
  endtask

  task automatic test_unbalanced();
    logic [DW-1:0] exp_d [3] = '{32'h1020, 32'h1022, 32'h1024};
    int ai;
    bit bv, fire;
    clear_all();
    m_tready = 1'b1;
    ai = 0;
    for (int c = 0; c < 9; c++) begin
      bv = (c % 3 == 0);
      s_a_tdata = DW'(32'h1000 + ai); s_b_tdata = DW'(32'h20 + ai);
      s_a_tvalid = 1'b1; s_b_tvalid = bv;
      #1 fire = s_a_tready;
      checks++;
      if (s_a_tready !== bv || s_b_tready !== bv) begin
        errors++; $display("FAIL unbal_tready c%0d: got %b%b want %b%b", c, s_a_tready, s_b_tready, bv, bv);
      end
      step();
      if (fire) ai++;
    end
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    idle(3);
    checks++;
    if (q_data.size() != 3) begin
      errors++; $display("FAIL unbal_count: got %0d beats want 3", q_data.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_data[i] !== exp_d[i]) begin
          errors++; $display("FAIL unbal_beat%0d: got %h want %h", i, q_data[i], exp_d[i]);
        end
      end
  endtask

  task automatic test_tlast_clear();
    clear_all();
    m_tready = 1'b1;
    run_join(32'h7, 32'h8, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 32'hF || q_last[0] !== 1'b1) begin
      errors++; $display("FAIL mismatch_beat: n=%0d got %h/%b want 0000000f/1", q_data.size(),
                         q_data.size() ? q_data[0] : '0, q_data.size() ? q_last[0] : 1'b0);
    end
    checks++;
    if (sts_tlast_err !== 1'b1 || sts_beat_cnt !== 1 || sts_pkt_cnt !== 1) begin
      errors++; $display("FAIL mismatch_sts: err=%b beat=%0d pkt=%0d want 1/1/1", sts_tlast_err, sts_beat_cnt, sts_pkt_cnt);
    end
    m_tready = 1'b0;
    run_join(32'h1, 32'h1, 1'b0, 1'b0);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h2) begin
      errors++; $display("FAIL clear_prep: valid=%b data=%h want 1/00000002", m_tvalid, m_tdata);
    end
    m_tready = 1'b1; cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    checks++;
    if ({sts_beat_cnt, sts_pkt_cnt, sts_ovf_cnt, sts_tlast_err} !== '0) begin
      errors++; $display("FAIL clear_wins: beat=%0d pkt=%0d ovf=%0d err=%b want 0",
                         sts_beat_cnt, sts_pkt_cnt, sts_ovf_cnt, sts_tlast_err);
    end
    checks++;
    if (q_data.size() != 2 || q_data[1] !== 32'h2 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL clear_no_flush: n=%0d valid=%b want 2 beats, valid 0", q_data.size(), m_tvalid);
    end
  endtask

  task automatic test_async_reset();
    clear_all();
    m_tready = 1'b0;
    run_join(32'h1, 32'h2, 1'b0, 1'b0);
    run_join(32'h3, 32'h4, 1'b0, 1'b0);
    s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++; $display("FAIL areset_prep: m_tvalid=%b want 1", m_tvalid);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || s_a_tready !== 1'b0 || s_b_tready !== 1'b0) begin
      errors++; $display("FAIL areset_async: valid=%b data=%h tready=%b%b want 0", m_tvalid, m_tdata, s_a_tready, s_b_tready);
    end
    s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
    #2 ARESETN = 1'b1;
    step();
    m_tready = 1'b1;
    q_data.delete(); q_last.delete(); q_cyc.delete();
    run_join(32'h5, 32'h5, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 32'hA) begin
      errors++; $display("FAIL areset_after: n=%0d first=%h want 1 beat 0000000a", q_data.size(),
                         q_data.size() ? q_data[0] : '0);
    end
    checks++;
    if (sts_beat_cnt !== 1) begin
      errors++; $display("FAIL areset_beat_cnt: got %0d want 1", sts_beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_unbalanced();
    test_tlast_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
